// File: rtl/cpu_types_pkg.sv
// Shared types for the core: data-cache controller states and the
// address-field view of a byte address for the default cache geometry.
package cpu_types_pkg;

    localparam int DCACHE_SETS  = 8;
    localparam int DCACHE_WORDS = 2;
    localparam int DIDX_W       = $clog2(DCACHE_SETS);
    localparam int DBLK_W       = (DCACHE_WORDS > 1) ? $clog2(DCACHE_WORDS) : 1;
    localparam int DTAG_W       = 30 - DIDX_W - $clog2(DCACHE_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        FLUSH,
        FLUSH_WB,
        DONE
    } dcache_state_t;

    typedef struct packed {
        logic [DTAG_W-1:0] tag;
        logic [DIDX_W-1:0] idx;
        logic [DBLK_W-1:0] blkoff;
        logic [1:0]        bytoff;
    } dcachef_t;

endpackage

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a single
// LL/SC link register and a flush-on-halt sequencer.
module dcache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int IDX = $clog2(SETS);
    localparam int OFF = $clog2(WORDS);
    localparam int TAG = 30 - IDX - OFF;
    localparam int CW  = (OFF > 0) ? OFF : 1;
    localparam int LW  = IDX + OFF;

    // Flat word index of word c inside line i.
    function automatic logic [LW-1:0] word_sel(input logic [IDX-1:0] i, input logic [CW-1:0] c);
        return (LW'(i) << OFF) | LW'(c);
    endfunction

    // Word-aligned memory address of word c of line i carrying tag t.
    function automatic logic [31:0] mk_addr(input logic [TAG-1:0] t, input logic [IDX-1:0] i,
                                            input logic [CW-1:0] c);
        return (32'(t) << (2 + OFF + IDX)) | (32'(i) << (2 + OFF)) | (32'(c) << 2);
    endfunction

    // Storage: data and tags are never reset, only the valid/dirty state is.
    logic [31:0]    data_arr [SETS*WORDS];
    logic [TAG-1:0] tag_arr  [SETS];
    logic [SETS-1:0] valid;
    logic [SETS-1:0] dirty;

    dcache_state_t  state;
    logic [CW-1:0]  cnt;
    logic [IDX-1:0] fidx;
    logic [IDX-1:0] miss_idx;
    logic [TAG-1:0] miss_tag;
    logic           link_valid;
    logic [29:0]    link_addr;

    // Request decode.
    logic [TAG-1:0] req_tag;
    logic [IDX-1:0] req_idx;
    logic [LW-1:0]  req_word;
    logic           hit, is_store, is_sc, is_ll, sc_fail, link_match;
    logic           idle_active, do_hit, do_fail, do_miss;
    logic           cnt_last, fidx_last;
    logic [IDX-1:0] wb_idx;
    logic           unused_bytoff;

    assign req_tag       = dmemaddr[31 -: TAG];
    assign req_idx       = dmemaddr[2+OFF +: IDX];
    assign req_word      = dmemaddr[2 +: LW];
    assign unused_bytoff = ^dmemaddr[1:0];

    assign hit         = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign is_store    = dmemWEN;
    assign is_sc       = dmemWEN && datomic;
    assign is_ll       = dmemREN && !dmemWEN && datomic;
    assign link_match  = (link_addr == dmemaddr[31:2]);
    assign sc_fail     = is_sc && !(link_valid && link_match);

    // Requests are only serviced in IDLE; halt wins over any request.
    assign idle_active = (state == IDLE) && !halt && (dmemREN || dmemWEN);
    assign do_fail     = idle_active && sc_fail;
    assign do_hit      = idle_active && !sc_fail && hit;
    assign do_miss     = idle_active && !sc_fail && !hit;

    assign cnt_last    = (cnt == CW'(WORDS - 1));
    assign fidx_last   = (fidx == IDX'(SETS - 1));
    assign wb_idx      = (state == FLUSH_WB) ? fidx : miss_idx;

    // Pipeline-facing response and memory-side request, all derived from
    // registered state so daddr/dstore hold steady while dwait is high.
    always_comb begin
        dhit     = do_hit || do_fail;
        dmemload = 32'd0;
        if (do_hit) begin
            dmemload = is_sc ? 32'd1 : data_arr[req_word];
        end
        dREN   = (state == FILL);
        dWEN   = (state == WB) || (state == FLUSH_WB);
        daddr  = 32'd0;
        dstore = 32'd0;
        if (dWEN) begin
            daddr  = mk_addr(tag_arr[wb_idx], wb_idx, cnt);
            dstore = data_arr[word_sel(wb_idx, cnt)];
        end else if (dREN) begin
            daddr  = mk_addr(miss_tag, miss_idx, cnt);
        end
    end

    // Data, tag and miss-address registers: store hits, line fills, miss capture.
    always_ff @(posedge CLK) begin
        if (do_hit && is_store) begin
            data_arr[req_word] <= dmemstore;
        end
        if (do_miss) begin
            miss_idx <= req_idx;
            miss_tag <= req_tag;
        end
        if (state == FILL && !dwait) begin
            data_arr[word_sel(miss_idx, cnt)] <= dload;
            if (cnt_last) begin
                tag_arr[miss_idx] <= miss_tag;
            end
        end
    end

    // Controller FSM with valid/dirty bookkeeping, link register and flush sequencing.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            cnt        <= '0;
            fidx       <= '0;
            valid      <= '0;
            dirty      <= '0;
            link_valid <= 1'b0;
            link_addr  <= '0;
            flushed    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        fidx  <= '0;
                        state <= FLUSH;
                    end else if (do_hit) begin
                        if (is_store) begin
                            dirty[req_idx] <= 1'b1;
                            if (link_match) begin
                                link_valid <= 1'b0;
                            end
                        end else if (is_ll) begin
                            link_valid <= 1'b1;
                            link_addr  <= dmemaddr[31:2];
                        end
                    end else if (do_miss) begin
                        cnt   <= '0;
                        state <= (valid[req_idx] && dirty[req_idx]) ? WB : FILL;
                    end
                end
                WB: begin
                    if (!dwait) begin
                        if (cnt_last) begin
                            dirty[miss_idx] <= 1'b0;
                            cnt             <= '0;
                            state           <= FILL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (!dwait) begin
                        if (cnt_last) begin
                            valid[miss_idx] <= 1'b1;
                            dirty[miss_idx] <= 1'b0;
                            cnt             <= '0;
                            state           <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (dirty[fidx]) begin
                        cnt   <= '0;
                        state <= FLUSH_WB;
                    end else if (fidx_last) begin
                        flushed <= 1'b1;
                        state   <= DONE;
                    end else begin
                        fidx <= fidx + 1'b1;
                    end
                end
                FLUSH_WB: begin
                    if (!dwait) begin
                        if (cnt_last) begin
                            dirty[fidx] <= 1'b0;
                            cnt         <= '0;
                            if (fidx_last) begin
                                flushed <= 1'b1;
                                state   <= DONE;
                            end else begin
                                fidx  <= fidx + 1'b1;
                                state <= FLUSH;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: behavioural word memory with fixed wait states,
// a transaction log, a vector table for load/store/LL/SC and hand-written
// sequences for eviction order, flush, and reset during a write-back.
module tb_dcache;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, datomic, halt;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN, dwait;
    logic [31:0] dmemload, daddr, dstore, dload;

    dcache #(.SETS(8), .WORDS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    // Memory model: each transaction sees LAT busy cycles then completes.
    logic [31:0] mem [1024];
    logic        mem_init = 1'b0;
    int          wcnt  = 0;
    int          txn_n = 0;
    logic [31:0] log_addr [512];
    logic [31:0] log_data [512];
    logic        log_we   [512];

    function automatic logic [31:0] init_val(input int i);
        return 32'hAAAA0000 + 32'(i) - 32'd15;
    endfunction

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (dREN || dWEN) begin
            if (wcnt < LAT) begin
                wcnt <= wcnt + 1;
            end else begin
                wcnt <= 0;
                if (dWEN) mem[daddr[11:2]] <= dstore;
                if (txn_n < 512) begin
                    log_addr[txn_n] <= daddr;
                    log_data[txn_n] <= dWEN ? dstore : dload;
                    log_we[txn_n]   <= dWEN;
                end
                txn_n <= txn_n + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    assign dwait = (dREN || dWEN) && (wcnt < LAT);
    assign dload = mem[daddr[11:2]];

    // Protocol monitors: exclusive read/write, address held while busy.
    int          both_err = 0;
    int          stab_err = 0;
    logic        prev_wait = 1'b0;
    logic        prev_rst  = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    always @(negedge CLK) begin
        if (dREN && dWEN) both_err <= both_err + 1;
        if (prev_wait && prev_rst && nRST && (daddr != prev_addr)) stab_err <= stab_err + 1;
        prev_wait <= dwait;
        prev_addr <= daddr;
        prev_rst  <= nRST;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_log(input string nm, input int k, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        chk({nm, "_we"},   64'(log_we[k]),   64'(we));
        chk({nm, "_addr"}, 64'(log_addr[k]), 64'(a));
        chk({nm, "_data"}, 64'(log_data[k]), 64'(d));
    endtask

    // Present one request from posedge+1 until dhit, drop it after the next edge.
    task automatic do_req(input logic ren, input logic wen, input logic at,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] ld, output int cyc);
        logic seen;
        dmemREN = ren; dmemWEN = wen; datomic = at; dmemaddr = a; dmemstore = d;
        cyc = 0; ld = 32'd0; seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            cyc++;
            if (dhit) begin
                ld = dmemload;
                seen = 1'b1;
                break;
            end
        end
        chk("req_completed", 64'(seen), 64'd1);
        @(posedge CLK);
        #1;
        dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0; dmemaddr = 32'd0; dmemstore = 32'd0;
    endtask

    typedef struct {
        logic        ren, wen, at;
        logic [31:0] addr, wdata, exp_load;
        logic        chk_ld;
        int          exp_cyc, exp_txn;
    } vec_t;

    function automatic vec_t mkv(input logic ren, input logic wen, input logic at,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] el, input logic cl, input int ec, input int et);
        vec_t v;
        v.ren = ren; v.wen = wen; v.at = at; v.addr = a; v.wdata = d;
        v.exp_load = el; v.chk_ld = cl; v.exp_cyc = ec; v.exp_txn = et;
        return v;
    endfunction

    localparam int NV = 20;
    vec_t vt [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ld;
        int          cyc, t0, n;
        logic        seen, done;

        nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
        dmemaddr = 32'd0; dmemstore = 32'd0;

        //           ren wen at  addr        wdata        exp_load      chk cyc txn
        vt[0]  = mkv(1, 0, 1, 32'h80,  32'h0,  32'hAAAA0011, 1, 8,  2);
        vt[1]  = mkv(0, 1, 1, 32'h80,  32'h5,  32'h1,        1, 1,  0);
        vt[2]  = mkv(1, 0, 0, 32'h80,  32'h0,  32'h5,        1, 1,  0);
        vt[3]  = mkv(0, 1, 1, 32'h80,  32'h7,  32'h0,        1, 1,  0);
        vt[4]  = mkv(1, 0, 0, 32'h80,  32'h0,  32'h5,        1, 1,  0);
        vt[5]  = mkv(1, 0, 1, 32'h80,  32'h0,  32'h5,        1, 1,  0);
        vt[6]  = mkv(0, 1, 0, 32'h80,  32'h9,  32'h0,        0, 1,  0);
        vt[7]  = mkv(0, 1, 1, 32'h80,  32'hB,  32'h0,        1, 1,  0);
        vt[8]  = mkv(1, 0, 0, 32'h80,  32'h0,  32'h9,        1, 1,  0);
        vt[9]  = mkv(1, 0, 1, 32'h80,  32'h0,  32'h9,        1, 1,  0);
        vt[10] = mkv(0, 1, 1, 32'h84,  32'h3,  32'h0,        1, 1,  0);
        vt[11] = mkv(1, 0, 0, 32'h84,  32'h0,  32'hAAAA0012, 1, 1,  0);
        vt[12] = mkv(1, 0, 1, 32'h100, 32'h0,  32'hAAAA0031, 1, 14, 4);
        vt[13] = mkv(1, 0, 0, 32'h80,  32'h0,  32'h9,        1, 8,  2);
        vt[14] = mkv(0, 1, 1, 32'h100, 32'h55, 32'h1,        1, 8,  2);
        vt[15] = mkv(1, 0, 0, 32'h100, 32'h0,  32'h55,       1, 1,  0);
        vt[16] = mkv(1, 1, 0, 32'h104, 32'h77, 32'h0,        0, 1,  0);
        vt[17] = mkv(1, 0, 0, 32'h104, 32'h0,  32'h77,       1, 1,  0);
        vt[18] = mkv(1, 0, 0, 32'h0,   32'h0,  32'hAAA9FFF1, 1, 14, 4);
        vt[19] = mkv(0, 1, 1, 32'h100, 32'h66, 32'h0,        1, 1,  0);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dhit",    64'(dhit),     64'd0);
        chk("rst_dmemload", 64'(dmemload), 64'd0);
        chk("rst_flushed", 64'(flushed),  64'd0);
        chk("rst_dREN",    64'(dREN),     64'd0);
        chk("rst_dWEN",    64'(dWEN),     64'd0);
        chk("rst_daddr",   64'(daddr),    64'd0);
        chk("rst_dstore",  64'(dstore),   64'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Cold miss, hit on the second word, store hit, dirty eviction.
        do_req(1, 0, 0, 32'h40, 32'h0, ld, cyc);
        chk("cold_load", 64'(ld), 64'hAAAA0001);
        chk("cold_cycles", 64'(cyc), 64'd8);
        chk_log("cold_rd0", 0, 1'b0, 32'h40, 32'hAAAA0001);
        chk_log("cold_rd1", 1, 1'b0, 32'h44, 32'hAAAA0002);
        do_req(1, 0, 0, 32'h44, 32'h0, ld, cyc);
        chk("hit44_load", 64'(ld), 64'hAAAA0002);
        chk("hit44_cycles", 64'(cyc), 64'd1);
        do_req(0, 1, 0, 32'h40, 32'h12345678, ld, cyc);
        chk("sthit_cycles", 64'(cyc), 64'd1);
        t0 = txn_n;
        do_req(1, 0, 0, 32'h240, 32'h0, ld, cyc);
        chk("evict_load", 64'(ld), 64'hAAAA0081);
        chk("evict_cycles", 64'(cyc), 64'd14);
        chk("evict_txns", 64'(txn_n - t0), 64'd4);
        chk_log("evict_wb0", t0,     1'b1, 32'h40,  32'h12345678);
        chk_log("evict_wb1", t0 + 1, 1'b1, 32'h44,  32'hAAAA0002);
        chk_log("evict_rd0", t0 + 2, 1'b0, 32'h240, 32'hAAAA0081);
        chk_log("evict_rd1", t0 + 3, 1'b0, 32'h244, 32'hAAAA0082);

        // LL/SC and store vectors.
        for (int i = 0; i < NV; i++) begin
            t0 = txn_n;
            do_req(vt[i].ren, vt[i].wen, vt[i].at, vt[i].addr, vt[i].wdata, ld, cyc);
            if (vt[i].chk_ld) chk($sformatf("vec%0d_load", i), 64'(ld), 64'(vt[i].exp_load));
            chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vt[i].exp_cyc));
            chk($sformatf("vec%0d_txns", i), 64'(txn_n - t0), 64'(vt[i].exp_txn));
        end

        // Dirty lines at idx 1 and 5, then halt with a request still presented.
        do_req(0, 1, 0, 32'h08, 32'h1111, ld, cyc);
        chk("idx1_cycles", 64'(cyc), 64'd8);
        do_req(0, 1, 0, 32'h28, 32'h5555, ld, cyc);
        chk("idx5_cycles", 64'(cyc), 64'd8);
        do_req(0, 1, 0, 32'h2C, 32'h5556, ld, cyc);
        chk("idx5b_cycles", 64'(cyc), 64'd1);
        t0 = txn_n;
        halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h08;
        seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (dhit) seen = 1'b1;
            if (flushed) begin
                done = 1'b1;
                break;
            end
        end
        chk("flush_done", 64'(done), 64'd1);
        chk("flush_no_dhit", 64'(seen), 64'd0);
        chk("flush_txns", 64'(txn_n - t0), 64'd4);
        chk_log("flush_w0", t0,     1'b1, 32'h08, 32'h1111);
        chk_log("flush_w1", t0 + 1, 1'b1, 32'h0C, 32'hAAA9FFF4);
        chk_log("flush_w2", t0 + 2, 1'b1, 32'h28, 32'h5555);
        chk_log("flush_w3", t0 + 3, 1'b1, 32'h2C, 32'h5556);
        repeat (4) @(negedge CLK);
        chk("flushed_held", 64'(flushed), 64'd1);
        chk("done_no_dhit", 64'(dhit), 64'd0);
        chk("done_no_traffic", 64'({dREN, dWEN}), 64'd0);

        // Reset during a write-back with dwait high.
        @(posedge CLK);
        #1 nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemaddr = 32'd0;
        #1 chk("rst_clears_flushed", 64'(flushed), 64'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        do_req(0, 1, 0, 32'h40, 32'hBEEF, ld, cyc);
        chk("rst_st_cycles", 64'(cyc), 64'd8);
        t0 = txn_n;
        dmemREN = 1'b1; dmemaddr = 32'h240;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (dWEN && dwait) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wb_started", 64'(seen), 64'd1);
        #1 nRST = 1'b0;
        #1;
        chk("midrst_dWEN",   64'(dWEN),     64'd0);
        chk("midrst_dREN",   64'(dREN),     64'd0);
        chk("midrst_daddr",  64'(daddr),    64'd0);
        chk("midrst_dstore", 64'(dstore),   64'd0);
        chk("midrst_dhit",   64'(dhit),     64'd0);
        chk("midrst_load",   64'(dmemload), 64'd0);
        dmemREN = 1'b0; dmemaddr = 32'd0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        chk("midrst_no_write", 64'(txn_n - t0), 64'd0);
        do_req(1, 0, 0, 32'h40, 32'h0, ld, cyc);
        chk("postrst_load", 64'(ld), 64'h12345678);
        chk("postrst_miss_cycles", 64'(cyc), 64'd8);

        // Clean flush: flushed rises SETS+1 cycles after halt.
        halt = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (flushed) break;
            n++;
        end
        chk("clean_flush_latency", 64'(n), 64'd9);

        chk("never_both_ren_wen", 64'(both_err), 64'd0);
        chk("daddr_stable_in_wait", 64'(stab_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache.md
Name: dcache

Overview:
- Per-core L1 data cache sitting directly downstream of the pipeline's memory stage.
- Consumes the pipeline's memory request: dmemREN, dmemWEN, datomic, dmemaddr, dmemstore and halt.
- Returns dhit and dmemload, and issues word transactions to the memory/bus side.
- Direct-mapped, write-back, write-allocate.
- Supports LL/SC through a single link register.
- Writes back all dirty lines on halt, then asserts flushed.

Parameters:
SETS, 8, number of lines; power of 2, ≥2
WORDS, 2, words per line; power of 2, ≥1
- Derived widths: IDX = log2(SETS), OFF = log2(WORDS), TAG = 30-IDX-OFF.
- Address split: [31:2+OFF+IDX] tag, [2+OFF+IDX-1:2+OFF] index, [2+OFF-1:2] word offset, [1:0] ignored.

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
dmemREN  in  1  load request from memory stage
dmemWEN  in  1  store request from memory stage
datomic  in  1  request is LL (with REN) or SC (with WEN)
dmemaddr  in  32  byte address
dmemstore  in  32  store data
halt  in  1  core halted; start flush
dhit  out  1  request complete this cycle
dmemload  out  32  load data, or SC result (1 = success, 0 = fail)
flushed  out  1  flush finished (sticky)
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address, [1:0]=0
dstore  out  32  memory write data
dload  in  32  memory read data
dwait  in  1  memory busy; transaction completes on the cycle dwait=0

Behaviour:
- Reset: all valid/dirty bits 0; link_valid 0; state IDLE; flush index 0; all outputs 0.
- Data and tag arrays need no reset.
- IDLE, hit = valid[idx] && tag[idx]==addr tag:
  - Load hit: dhit=1 and dmemload=word, combinationally, same cycle.
  - Store hit: dhit=1; word written and dirty set at the next edge.
  - The pipeline drops the request the cycle after dhit, so each request sees exactly one dhit.
- IDLE, miss:
  - Dirty victim: go to WB (word counter 0), else go to FILL.
- WB:
  - dWEN=1, daddr = {victim tag, idx, counter, 00}, dstore = victim word.
  - Counter advances when dwait=0.
  - After the last word: clear dirty, go to FILL.
- FILL:
  - dREN=1, daddr = {req tag, idx, counter, 00}.
  - On dwait=0, write dload into the line.
  - After the last word: set valid and tag, clear dirty, return to IDLE; the request then hits next cycle.
  - Miss latency with clean victim = WORDS transactions + 1 cycle.
- dREN and dWEN are never both 1.
- daddr is stable while dwait=1.
- REN and WEN both high: treated as a store.
- LL (REN && datomic): behaves as a load; on dhit, link_addr = dmemaddr[31:2] and link_valid=1.
- SC (WEN && datomic):
  - Success requires link_valid && link_addr matches.
  - Success: the write proceeds as a normal store (miss handling included); dhit with dmemload=1; link_valid cleared.
  - Fail: dhit the same cycle in IDLE with dmemload=0; no write; no memory traffic.
- Any successful store (plain or SC) to link_addr clears link_valid.
- Halt:
  - On halt=1 in IDLE, go to FLUSH; dhit is forced 0 from then on and requests are ignored.
  - An in-progress WB or FILL completes first.
  - FLUSH scans idx 0..SETS-1; each dirty line is written back as in WB.
  - After the last set: state DONE, flushed=1, held until reset.
  - No dirty lines: flushed asserts SETS+1 cycles after halt.
- Reset mid-transaction: everything returns to reset values immediately; the partial memory write is abandoned.

Decomposition:
- cpu_types_pkg gets:
  - dcache_state_t enum: IDLE, WB, FILL, FLUSH, FLUSH_WB, DONE.
  - Address-field struct dcachef_t {tag, idx, blkoff, bytoff}.
- No sub-module; the arrays are plain registers inside dcache.

Test Plan:
- Cold load miss 0x40, memory holding 0x40=0xAAAA0001, 0x44=0xAAAA0002, dwait low after 2 cycles → two dREN transactions at 0x40 and 0x44, then dhit=1 with dmemload=0xAAAA0001; a subsequent load of 0x44 hits in 1 cycle.
- Store 0x12345678 to 0x40 (hit), then load 0x240 (same index, different tag) → dWEN transactions at 0x40 (data 0x12345678) and 0x44 precede dREN at 0x240.
- LL 0x80, then SC 0x80 data 5 → dmemload=1 and a load of 0x80 returns 5; a second SC 0x80 → dmemload=0 with memory unchanged.
- LL 0x80, plain store 0x80, then SC 0x80 → dmemload=0; LL 0x80 then SC 0x84 → dmemload=0.
- Dirty lines at idx 1 and 5, then halt=1 → exactly 2×WORDS dWEN transactions in ascending idx order, then flushed=1 held; dhit stays 0.
- Assert nRST low during a WB with dwait high → dWEN drops immediately, all outputs 0; a first load after reset misses.
